// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display:
// active-low segment patterns, dash/blank codes and the decimal range limit.
package seg_disp_pkg;

    // Element [n] is the active-low {g,f,e,d,c,b,a} pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_PATTERN = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        if (code <= 4'd9) begin
            return SEG_PATTERN[code];
        end
        return SEG_BLANK;
    endfunction

    // Largest value representable on the given number of decimal digits.
    function automatic longint unsigned max_display(input int digits);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bin_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one input bit per clock,
// BIN_W clocks per conversion, with a range-overflow flag captured at start.
module bin_bcd_seq
    import seg_disp_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(max_display(DIGITS));

    logic [BIN_W-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_step;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             accept;

    // A new start is accepted when idle or in the final cycle, so a queued
    // conversion can follow without a gap in busy.
    assign accept = start && (!busy_q || done_q);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // The first bit is shifted in on the start edge itself.
            busy_q  <= 1'b1;
            done_q  <= (BIN_W == 1);
            cnt_q   <= CNT_W'(1);
            shift_q <= value << 1;
            bcd_q   <= BCD_W'(value[BIN_W-1]);
            ovf_q   <= (64'(value) > MAX_VAL);
        end else if (done_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (busy_q) begin
            bcd_q   <= bcd_step;
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q + 1'b1;
            done_q  <= (cnt_q == CNT_W'(BIN_W - 1));
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display driver: converts a binary value to BCD
// with a one-deep request queue and scans the digits with registered outputs.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int BIN_W     = 8,
    parameter int DIGITS    = 4,
    parameter int SCAN_BITS = 8,
    parameter int LZ_BLANK  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic [7:0]        dig,
    output logic [DIGITS-1:0] sel
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);

    logic                 conv_start;
    logic [BIN_W-1:0]     conv_value;
    logic                 conv_busy;
    logic                 conv_done;
    logic [BCD_W-1:0]     conv_bcd;
    logic                 conv_ovf;

    logic [BIN_W-1:0]     pend_q;
    logic                 pend_valid;
    logic                 pend_set;
    logic                 pend_clear;

    logic [BCD_W-1:0]     disp_bcd;
    logic                 disp_ovf;

    logic [SCAN_BITS-1:0] pre_q;
    logic [IDX_W-1:0]     idx_q;

    logic [3:0]           code;
    logic                 blank;
    logic [6:0]           seg_next;
    logic                 dp_next;
    logic [DIGITS-1:0]    sel_next;

    bin_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (conv_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_comb begin
        conv_start = 1'b0;
        conv_value = value;
        pend_set   = 1'b0;
        pend_clear = 1'b0;
        if (!conv_busy) begin
            conv_start = load;
        end else if (conv_done) begin
            // Final cycle: chain the queued request, or take a fresh load directly.
            if (pend_valid) begin
                conv_start = 1'b1;
                conv_value = pend_q;
                pend_set   = load;
                pend_clear = !load;
            end else begin
                conv_start = load;
            end
        end else begin
            pend_set = load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            pend_valid <= 1'b0;
            disp_bcd   <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            if (pend_set) begin
                pend_q     <= value;
                pend_valid <= 1'b1;
            end else if (pend_clear) begin
                pend_valid <= 1'b0;
            end
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                disp_ovf <= conv_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
            if (pre_q == '1) begin
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        code     = disp_bcd[4*idx_q +: 4];
        // A digit is a leading zero when it and every digit above it are zero.
        blank    = (LZ_BLANK != 0) && (idx_q != '0) && ((disp_bcd >> (4 * idx_q)) == '0);
        seg_next = seg_encode(code);
        if (disp_ovf) begin
            seg_next = SEG_DASH;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end
        dp_next  = ~dp_mask[idx_q];
        sel_next = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig <= 8'hFF;
            sel <= '1;
        end else begin
            dig <= {dp_next, seg_next};
            sel <= sel_next;
        end
    end

    assign busy = conv_busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: four parameterisations share the
// stimulus; a vector table covers decoding/blanking/dp, sequences cover timing.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] value;
    logic [7:0] dp_mask_all;

    logic       busy_a, busy_b, busy_c, busy_d;
    logic [7:0] dig_a, dig_b, dig_c, dig_d;
    logic [3:0] sel_a;
    logic [1:0] sel_b;
    logic [2:0] sel_c;
    logic [3:0] sel_d;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.BIN_W(8), .DIGITS(4), .SCAN_BITS(8), .LZ_BLANK(1)) u_a (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask_all[3:0]), .busy(busy_a), .dig(dig_a), .sel(sel_a));

    seg_scan_display #(.BIN_W(8), .DIGITS(2), .SCAN_BITS(2), .LZ_BLANK(1)) u_b (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask_all[1:0]), .busy(busy_b), .dig(dig_b), .sel(sel_b));

    seg_scan_display #(.BIN_W(8), .DIGITS(3), .SCAN_BITS(2), .LZ_BLANK(1)) u_c (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask_all[2:0]), .busy(busy_c), .dig(dig_c), .sel(sel_c));

    seg_scan_display #(.BIN_W(8), .DIGITS(4), .SCAN_BITS(2), .LZ_BLANK(0)) u_d (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask_all[3:0]), .busy(busy_d), .dig(dig_d), .sel(sel_d));

    typedef struct packed {
        logic [7:0]      value;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_a && n < 100) begin
            tick();
            n++;
        end
        if (busy_a) begin
            tests++;
            failed++;
            $display("FAIL %s: busy never fell", name);
        end
    endtask

    // Waits until instance inst selects digit d, then compares its dig output.
    task automatic check_digit(input string name, input int inst, input int d, input logic [7:0] exp);
        logic [7:0] want_sel, cur_sel, cur_dig;
        bit found;
        found    = 1'b0;
        want_sel = ~(8'b1 << d);
        cur_sel  = 8'hFF;
        cur_dig  = 8'hFF;
        for (int n = 0; n < 2000 && !found; n++) begin
            case (inst)
                0:       begin cur_sel = {4'hF, sel_a};  cur_dig = dig_a; end
                1:       begin cur_sel = {6'h3F, sel_b}; cur_dig = dig_b; end
                2:       begin cur_sel = {5'h1F, sel_c}; cur_dig = dig_c; end
                default: begin cur_sel = {4'hF, sel_d};  cur_dig = dig_d; end
            endcase
            if (cur_sel == want_sel) found = 1'b1;
            else tick();
        end
        if (found) begin
            check(name, 32'(cur_dig), 32'(exp));
        end else begin
            tests++;
            failed++;
            $display("FAIL %s: timeout waiting for sel=%b", name, want_sel);
        end
    endtask

    initial begin
        int busy_cnt;
        int run;
        bit bad;
        logic [2:0] sel_seq [3];

        vecs[0] = '{value: 8'd123, dp: 4'b0000, exp: {8'hFF, 8'hF9, 8'hA4, 8'hB0}};
        vecs[1] = '{value: 8'd0,   dp: 4'b0000, exp: {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[2] = '{value: 8'd255, dp: 4'b0001, exp: {8'hFF, 8'hA4, 8'h92, 8'h12}};
        vecs[3] = '{value: 8'd100, dp: 4'b1000, exp: {8'h7F, 8'hF9, 8'hC0, 8'hC0}};
        vecs[4] = '{value: 8'd9,   dp: 4'b0000, exp: {8'hFF, 8'hFF, 8'hFF, 8'h90}};
        vecs[5] = '{value: 8'd80,  dp: 4'b0010, exp: {8'hFF, 8'hFF, 8'h00, 8'hC0}};

        reset       = 1'b1;
        load        = 1'b0;
        value       = '0;
        dp_mask_all = '0;

        // Reset state, and a load coinciding with reset is ignored.
        tick();
        load  = 1'b1;
        value = 8'd42;
        tick();
        load = 1'b0;
        check("reset busy_a", 32'(busy_a), 32'd0);
        check("reset busy_b", 32'(busy_b), 32'd0);
        check("reset busy_c", 32'(busy_c), 32'd0);
        check("reset busy_d", 32'(busy_d), 32'd0);
        check("reset dig_a", 32'(dig_a), 32'hFF);
        check("reset sel_a", 32'(sel_a), 32'hF);
        check("reset sel_c", 32'(sel_c), 32'h7);
        reset = 1'b0;
        tick();
        check("post-reset sel_a", 32'(sel_a), 32'hE);
        check("post-reset dig_a", 32'(dig_a), 32'hC0);
        check("post-reset busy_a", 32'(busy_a), 32'd0);

        // Digit-3 row for value 123 and the 256-clock hold per digit.
        do_reset();
        start_load(8'd123);
        busy_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (busy_a) busy_cnt++;
            tick();
        end
        check("123 busy cycles", 32'(busy_cnt), 32'd8);
        run = 0;
        for (int n = 0; n < 600 && sel_a != 4'b1101; n++) tick();
        while (sel_a == 4'b1101 && run < 400) begin
            run++;
            tick();
        end
        check("digit hold clocks", 32'(run), 32'd256);

        // Table: decoding, leading-zero blanking and decimal points on u_a.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            dp_mask_all = {4'h0, vecs[i].dp};
            start_load(vecs[i].value);
            wait_idle($sformatf("vec%0d", i));
            tick();
            for (int d = 0; d < 4; d++) begin
                check_digit($sformatf("vec%0d d%0d", i, d), 0, d, vecs[i].exp[d]);
            end
        end
        dp_mask_all = '0;

        // Queued loads: 7, then 200 at busy cycle 3, overwritten by 45 at cycle 5.
        do_reset();
        start_load(8'd7);
        busy_cnt = 0;
        bad      = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (busy_a) busy_cnt++;
            if (n == 8)  check("queue pre-display", 32'(dig_a), 32'hC0);
            if (n == 9)  check("queue shows 7", 32'(dig_a), 32'hF8);
            if (n == 16) check("queue 7 held", 32'(dig_a), 32'hF8);
            if (n == 17) check("queue shows 45", 32'(dig_a), 32'h92);
            if (n >= 9 && dig_a == 8'hC0) bad = 1'b1;
            value = (n == 2) ? 8'd200 : 8'd45;
            load  = (n == 2) || (n == 4);
            tick();
        end
        load = 1'b0;
        check("queue busy cycles", 32'(busy_cnt), 32'd16);
        check("queue 200 never shown", 32'(bad), 32'd0);
        check_digit("queue 45 d1", 0, 1, 8'h99);
        check_digit("queue 45 d2", 0, 2, 8'hFF);

        // Overflow on two digits, then an in-range value.
        do_reset();
        start_load(8'd150);
        wait_idle("ovf 150");
        tick();
        check_digit("ovf 150 d0", 1, 0, 8'hBF);
        check_digit("ovf 150 d1", 1, 1, 8'hBF);
        start_load(8'd99);
        wait_idle("ovf 99");
        tick();
        check_digit("99 d0", 1, 0, 8'h90);
        check_digit("99 d1", 1, 1, 8'h90);

        // Three-digit scan order with a four-clock prescaler.
        sel_seq[0] = 3'b110;
        sel_seq[1] = 3'b101;
        sel_seq[2] = 3'b011;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            tick();
            if ((n % 4 == 0) || (n % 4 == 3)) begin
                check($sformatf("scan3 n%0d", n), 32'(sel_c), 32'(sel_seq[(n / 4) % 3]));
            end
        end

        // Reset in the middle of a conversion.
        do_reset();
        start_load(8'd9);
        wait_idle("abort pre");
        start_load(8'd123);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort dig", 32'(dig_a), 32'hFF);
        check("abort sel", 32'(sel_a), 32'hF);
        reset = 1'b0;
        bad   = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (busy_a || dig_a != 8'hC0) bad = 1'b1;
        end
        check("abort no update", 32'(bad), 32'd0);

        // No blanking, decimal point on digit 2 only.
        do_reset();
        dp_mask_all = 8'b0000_0100;
        start_load(8'd0);
        wait_idle("nolz");
        tick();
        check_digit("nolz d0", 3, 0, 8'hC0);
        check_digit("nolz d1", 3, 1, 8'hC0);
        check_digit("nolz d2", 3, 2, 8'h40);
        check_digit("nolz d3", 3, 3, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL take parameter BIN_W, default 8, meaning the width of the binary value to display.
REQ-002 The block SHALL take parameter DIGITS, default 4, meaning the number of multiplexed digits (2..8).
REQ-003 The block SHALL take parameter SCAN_BITS, default 8, meaning each digit is lit for 2^SCAN_BITS clocks.
REQ-004 The block SHALL take parameter LZ_BLANK, default 1, meaning leading-zero blanking is enabled when 1.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-007 The block SHALL have port load, input, 1, a request to display value.
REQ-008 The block SHALL have port value, input, BIN_W, the unsigned binary number to display.
REQ-009 The block SHALL have port dp_mask, input, DIGITS, the per-digit decimal point enable.
REQ-010 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-011 The block SHALL have port dig, output, 8, {dp, seg[6:0]}, all active-low.
REQ-012 The block SHALL have port sel, output, DIGITS, the active-low one-cold digit enable.

Function
REQ-013 A load sampled high while idle SHALL capture value and start a shift-add-3 BCD conversion of exactly BIN_W cycles.
- busy is high from cycle 1 through cycle BIN_W after the load edge.
- The display register updates atomically on the edge where busy falls.
REQ-014 A load while busy SHALL store value in a one-deep pending register; a later load while busy SHALL overwrite it.
- The pending conversion SHALL start in the cycle after the current one completes, with busy staying high continuously.
REQ-015 A value greater than 10^DIGITS-1 SHALL display a dash (seg 0111111) on every digit; no truncated digits are shown.
REQ-016 The scan prescaler SHALL count 0..2^SCAN_BITS-1; on wrap, the digit index SHALL increment and wrap from DIGITS-1 to 0, including for non-power-of-two DIGITS.
REQ-017 sel SHALL drive bit index low and all other bits high; dig and sel SHALL be registered and change on the same edge.
REQ-018 seg SHALL use the 0-9 active-low patterns 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; any other code SHALL produce 1111111.
REQ-019 With LZ_BLANK=1, digits above the most significant nonzero digit SHALL show 1111111, and digit 0 SHALL always be shown.
REQ-020 dp SHALL equal ~dp_mask[index]; it is unaffected by blanking and by overflow.

Reset
REQ-021 While reset is high: busy=0, sel all ones, dig=8'hFF, display register=0, pending empty, prescaler=0, index=0, and any conversion is aborted.
REQ-022 A load sampled in the same cycle as reset SHALL be ignored.
REQ-023 After reset deasserts, scanning SHALL start at digit 0 on the first edge, showing "0" (blanked above digit 0 when LZ_BLANK=1).

Structure
REQ-024 The segment-pattern constants, dash and blank codes, and a function computing 10^DIGITS-1 SHALL live in package seg_disp_pkg.
REQ-025 The iterative converter SHALL be sub-module bin_bcd_seq (start/value in; busy/done/bcd[4*DIGITS-1:0]/ovf out).

Verification
REQ-026 Reset, then load value=8'd123 with DIGITS=4 -> busy high for 8 cycles; the scan then shows blank, 1, 2, 3 on digits 3..0, each held for 256 clocks.
REQ-027 Load 8'd7, then load 8'd200 at busy cycle 3, then load 8'd45 at cycle 5 -> 7 is displayed, followed by 45 after 16 contiguous busy cycles; 200 is never shown.
REQ-028 With DIGITS=2, load 8'd150 -> both digits show 0111111; a following load of 8'd99 -> "99".
REQ-029 With DIGITS=3 and SCAN_BITS=2 -> the sel sequence is 110, 101, 011, 110, changing every 4 clocks.
REQ-030 Assert reset at busy cycle 4 -> busy=0 and dig=FF on the next edge; the previous display is not updated.
REQ-031 With dp_mask=4'b0100 and LZ_BLANK=0, load 0 -> "0000" with dp low only while sel=1011.
